sprite_plot_arbiter: RTL and testbench

//   Shares the single VGA-adapter pixel-write port among N sprite controllers (player, enemies, bullets).

---
 rtl/sprite_plot_arbiter_pkg.sv | 27 ++
 rtl/sprite_plot_arbiter_if.sv | 32 +++
 rtl/sprite_plot_arbiter_rr_select.sv | 35 +++
 rtl/sprite_plot_arbiter.sv | 140 ++++++++++++++
 tb/tb_sprite_plot_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_plot_arbiter_pkg.sv
// Shared sprite-engine definitions: VGA coordinate widths, pixel payload and arbiter state codes.
// Imported by the plot arbiter and by the sprite controllers that talk to it.
package thunder_pkg;

  localparam int unsigned X_W           = 8;
  localparam int unsigned Y_W           = 7;
  localparam int unsigned COLOUR_W      = 3;
  localparam int unsigned SPRITE_PIXELS = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // Index width for an N-way requester vector (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_plot_arbiter_if.sv
// Requester-side bundle and VGA-adapter pixel port of the sprite plot arbiter.
// master = arbiter view, slave = requester/adapter view.
interface sprite_plot_arbiter_if #(
  parameter int unsigned N = 4
);
  import thunder_pkg::*;

  logic [N-1:0]          req;
  logic [N-1:0]          req_last;
  logic [N-1:0]          req_plot;
  logic [N*X_W-1:0]      req_x;
  logic [N*Y_W-1:0]      req_y;
  logic [N*COLOUR_W-1:0] req_colour;

  logic [N-1:0]          gnt;
  logic                  busy;
  logic [X_W-1:0]        vga_x;
  logic [Y_W-1:0]        vga_y;
  logic [COLOUR_W-1:0]   vga_colour;
  logic                  vga_plot;

  modport master (
    input  req, req_last, req_plot, req_x, req_y, req_colour,
    output gnt, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output req, req_last, req_plot, req_x, req_y, req_colour,
    input  gnt, busy, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/sprite_plot_arbiter_rr_select.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping modulo N.
module rr_select
  import thunder_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req_i,
  input  logic [idx_w(N)-1:0]   ptr_i,
  output logic [N-1:0]          onehot_c_o,
  output logic [idx_w(N)-1:0]   idx_c_o,
  output logic                  valid_c_o
);

  localparam int unsigned IDX_W = idx_w(N);

  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    onehot_c_o = '0;
    idx_c_o    = '0;
    pos        = '0;
    found      = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      pos = IDX_W'((int'(ptr_i) + k) % int'(N));
      if (!found && req_i[pos]) begin
        onehot_c_o[pos] = 1'b1;
        idx_c_o         = pos;
        found           = 1'b1;
      end
    end
    valid_c_o = found;
  end

endmodule

// File: rtl/sprite_plot_arbiter.sv
// Grants the single VGA pixel-write port to one sprite controller per pass, round-robin.
// Build option PLAYER_PRIORITY_EN: requester 0 (player) always wins arbitration when requesting.
module sprite_plot_arbiter
  import thunder_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic                  clock,
  input  logic                  resetn,
  sprite_plot_arbiter_if.master bus
);

  localparam int unsigned IDX_W  = idx_w(N);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;

  logic [N-1:0]      rr_onehot, win_onehot;
  logic [IDX_W-1:0]  rr_idx, win_idx;
  logic              rr_valid, win_valid;
  logic              rel_done, rel_abort, rel_forced;
  pixel_t            pix;
  logic              plot;

  rr_select #(.N(N)) u_rr_select (
    .req_i      (bus.req),
    .ptr_i      (ptr_q),
    .onehot_c_o (rr_onehot),
    .idx_c_o    (rr_idx),
    .valid_c_o  (rr_valid)
  );

  // Winner selection, optionally overridden by the player.
  always_comb begin
    win_onehot = rr_onehot;
    win_idx    = rr_idx;
    win_valid  = rr_valid;
`ifdef PLAYER_PRIORITY_EN
    if (bus.req[0]) begin
      win_onehot = N'(1);
      win_idx    = '0;
      win_valid  = 1'b1;
    end
`endif
  end

  assign rel_done   = |(gnt_q & bus.req_plot & bus.req_last);
  assign rel_abort  = ~|(gnt_q & bus.req);
  assign rel_forced = (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Next-state logic for IDLE -> BUSY -> GAP -> IDLE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d = ARB_BUSY;
          gnt_d   = win_onehot;
          gidx_d  = win_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ARB_BUSY: begin
        hold_d = hold_q + HOLD_W'(1);
        if (rel_done || rel_abort || rel_forced) begin
          state_d = ARB_GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
`ifdef PLAYER_PRIORITY_EN
          if (gidx_q != '0) ptr_d = gidx_q;
`else
          ptr_d = gidx_q;
`endif
        end
      end
      ARB_GAP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(N - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  // One-hot AND-OR mux; gnt is zero outside BUSY so the VGA port idles at zero.
  always_comb begin
    pix  = '0;
    plot = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_q[i]) begin
        pix.x      = pix.x | bus.req_x[i*X_W +: X_W];
        pix.y      = pix.y | bus.req_y[i*Y_W +: Y_W];
        pix.colour = pix.colour | bus.req_colour[i*COLOUR_W +: COLOUR_W];
        plot       = plot | bus.req_plot[i];
      end
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.vga_x      = pix.x;
  assign bus.vga_y      = pix.y;
  assign bus.vga_colour = pix.colour;
  assign bus.vga_plot   = plot;

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Directed bench for sprite_plot_arbiter (N=4, MAX_HOLD=64): mux vector table plus pass/abort/forced/reset sequences.
module tb_sprite_plot_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sprite_plot_arbiter_if #(.N(4)) bus ();

  sprite_plot_arbiter #(.N(4), .MAX_HOLD(64)) dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] plot;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [2:0] c1;
    logic [7:0] xo;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       ep;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pix(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.req_x[8*i +: 8]      = x;
    bus.req_y[7*i +: 7]      = y;
    bus.req_colour[3*i +: 3] = c;
  endtask

  task automatic wait_gnt(input logic [3:0] exp, input int max_cycles, input string name);
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000) break;
    end
    check(name, 32'(bus.gnt), 32'(exp));
  endtask

  // One full 16-pixel pass by requester g, then GAP and re-arbitration.
  task automatic run_pass(input int g, input logic [3:0] exp_next);
    for (int p = 0; p < 16; p++) begin
      @(posedge clk); #1;
      bus.req_plot = 4'(1 << g);
      bus.req_last = (p == 15) ? 4'(1 << g) : 4'b0000;
      set_pix(g, 8'(16*g + p), 7'(p), 3'(p));
      @(negedge clk);
      check("pass_plot", 32'(bus.vga_plot), 32'd1);
      check("pass_x", 32'(bus.vga_x), 32'(16*g + p));
    end
    @(posedge clk); #1;
    bus.req_plot = '0;
    bus.req_last = '0;
    @(negedge clk);
    check("gap_gnt", 32'(bus.gnt), 32'd0);
    check("gap_busy", 32'(bus.busy), 32'd0);
    check("gap_plot", 32'(bus.vga_plot), 32'd0);
    @(negedge clk);
    check("arb_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("rr_next_gnt", 32'(bus.gnt), 32'(exp_next));
    check("rr_next_busy", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    vecs[0] = '{4'b1111, 8'd40,   7'd110,  3'd2, 8'd200,  8'd40,   7'd110,  3'd2, 1'b1};
    vecs[1] = '{4'b1101, 8'd40,   7'd110,  3'd2, 8'd17,   8'd40,   7'd110,  3'd2, 1'b0};
    vecs[2] = '{4'b0010, 8'd255,  7'd127,  3'd7, 8'd0,    8'd255,  7'd127,  3'd7, 1'b1};
    vecs[3] = '{4'b1101, 8'd0,    7'd0,    3'd0, 8'd255,  8'd0,    7'd0,    3'd0, 1'b0};
    vecs[4] = '{4'b0010, 8'h5A,   7'h2B,   3'd5, 8'hA5,   8'h5A,   7'h2B,   3'd5, 1'b1};

    rst_n          = 1'b0;
    bus.req        = '0;
    bus.req_last   = '0;
    bus.req_plot   = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_plot", 32'(bus.vga_plot), 32'd0);
    check("rst_x", 32'(bus.vga_x), 32'd0);
    check("rst_y", 32'(bus.vga_y), 32'd0);
    check("rst_colour", 32'(bus.vga_colour), 32'd0);

    // Round-robin over four full passes and one wrap
    @(posedge clk); #1;
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    @(negedge clk);
    check("rr_latency_idle", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("rr_first_gnt", 32'(bus.gnt), 32'b0001);
    run_pass(0, 4'b0010);
    run_pass(1, 4'b0100);
    run_pass(2, 4'b1000);
    run_pass(3, 4'b0001);
    run_pass(0, 4'b0010);

    // Mux isolation while requester 1 holds the grant
    bus.req_last = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.req_plot = vecs[i].plot;
      for (int j = 0; j < 4; j++) begin
        if (j == 1) set_pix(j, vecs[i].x1, vecs[i].y1, vecs[i].c1);
        else        set_pix(j, vecs[i].xo, 7'd99, 3'd6);
      end
      @(negedge clk);
      check("mux_gnt", 32'(bus.gnt), 32'b0010);
      check("mux_x", 32'(bus.vga_x), 32'(vecs[i].ex));
      check("mux_y", 32'(bus.vga_y), 32'(vecs[i].ey));
      check("mux_colour", 32'(bus.vga_colour), 32'(vecs[i].ec));
      check("mux_plot", 32'(bus.vga_plot), 32'(vecs[i].ep));
    end

    // Asynchronous reset in the middle of a pass
    @(posedge clk); #1;
    bus.req_plot = 4'b1111;
    rst_n        = 1'b0;
    #1;
    check("rst_mid_gnt", 32'(bus.gnt), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_plot", 32'(bus.vga_plot), 32'd0);
    @(posedge clk); #1;
    rst_n        = 1'b1;
    bus.req_plot = '0;
    @(negedge clk);
    check("rst_rel_idle", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("rst_rel_gnt", 32'(bus.gnt), 32'b0001);

    // Abort of requester 0 (ptr -> 0), then grant requester 2
    @(posedge clk); #1;
    bus.req = 4'b0000;
    @(negedge clk);
    check("abort0_hold", 32'(bus.gnt), 32'b0001);
    check("abort0_noplot", 32'(bus.vga_plot), 32'd0);
    @(negedge clk);
    check("abort0_rel", 32'(bus.gnt), 32'd0);
    @(posedge clk); #1;
    bus.req = 4'b0100;
    wait_gnt(4'b0100, 10, "grant2");

    // Requester 2 aborts after five pixels; ptr=2 so requester 3 wins next
    for (int p = 0; p < 5; p++) begin
      @(posedge clk); #1;
      bus.req_plot = 4'b0100;
      set_pix(2, 8'(100 + p), 7'(50 + p), 3'(p));
      @(negedge clk);
      check("abort2_plot", 32'(bus.vga_plot), 32'd1);
    end
    @(posedge clk); #1;
    bus.req      = 4'b1011;
    bus.req_plot = '0;
    @(negedge clk);
    check("abort2_still", 32'(bus.gnt), 32'b0100);
    check("abort2_noplot", 32'(bus.vga_plot), 32'd0);
    @(negedge clk);
    check("abort2_rel", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("abort2_idle", 32'(bus.gnt), 32'd0);
    @(negedge clk);
`ifdef PLAYER_PRIORITY_EN
    check("after_abort_winner", 32'(bus.gnt), 32'b0001);
`else
    check("after_abort_winner", 32'(bus.gnt), 32'b1000);
`endif

    // Forced release: holder never signals last, grant lasts exactly 64 BUSY cycles
    for (int k = 1; k < 64; k++) @(negedge clk);
    check("forced_hold63", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("forced_rel_gnt", 32'(bus.gnt), 32'd0);
    check("forced_rel_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("forced_idle", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("recompete_gnt", 32'(bus.gnt), 32'b0001);

    // Player priority: after idx0 abort ptr=0, req=1011
    @(posedge clk); #1;
    bus.req = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req = 4'b1011;
`ifdef PLAYER_PRIORITY_EN
    wait_gnt(4'b0001, 10, "priority_gnt");
`else
    wait_gnt(4'b0010, 10, "priority_gnt");
`endif

    // Sole requester wins again after completing its pass
    @(posedge clk); #1;
    bus.req      = 4'b0010;
    bus.req_plot = 4'b0010;
    bus.req_last = 4'b0010;
    set_pix(1, 8'd7, 7'd8, 3'd1);
`ifndef PLAYER_PRIORITY_EN
    @(negedge clk);
    check("last_plot", 32'(bus.vga_plot), 32'd1);
`endif
    @(posedge clk); #1;
    bus.req_plot = '0;
    bus.req_last = '0;
    bus.req      = 4'b0010;
    wait_gnt(4'b0010, 10, "rewin_alone");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
